// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM command/address/DQ bus between the init,
// auto-refresh, write and read sequencers. Refresh has priority over
// write/read, and write/read alternate when both are pending. Every hand-over
// passes through at least one NOP arbitration cycle. Each grant is a
// registered one-cycle pulse that falls on the first cycle of the new owner.
module sdram_arbiter #(
    parameter int unsigned ADDR_BITS = 12,
    parameter int unsigned BA_BITS   = 2,
    parameter int unsigned DQ_BITS   = 8
) (
    input  logic                 sdram_clk,
    input  logic                 rst_n,

    input  logic [3:0]           init_cmd,
    input  logic [ADDR_BITS-1:0] init_addr,
    input  logic                 init_done,

    input  logic                 aref_req,
    input  logic [3:0]           aref_cmd,
    input  logic                 aref_done,
    output logic                 aref_en,

    input  logic                 wr_req,
    input  logic [3:0]           wr_cmd,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [BA_BITS-1:0]   wr_ba,
    input  logic [DQ_BITS-1:0]   wr_data,
    input  logic                 wr_done_all,
    input  logic                 wr_go_aref,
    output logic                 wr_en,

    input  logic                 rd_req,
    input  logic [3:0]           rd_cmd,
    input  logic [ADDR_BITS-1:0] rd_addr,
    input  logic [BA_BITS-1:0]   rd_ba,
    input  logic                 rd_done_all,
    input  logic                 rd_go_aref,
    output logic                 rd_en,

    output logic [3:0]           sdram_cmd,
    output logic [ADDR_BITS-1:0] sdram_addr,
    output logic [BA_BITS-1:0]   sdram_ba,
    output logic [DQ_BITS-1:0]   sdram_dq,
    output logic                 sdram_dq_oe
);

    localparam int unsigned     CMD_BITS = 4;
    localparam logic [CMD_BITS-1:0] CMD_NOP = 4'b0111;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARB   = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } state_e;

    // Which of write/read owned the bus most recently; the other wins a tie.
    typedef enum logic {
        RW_READ  = 1'b0,
        RW_WRITE = 1'b1
    } rw_e;

    state_e state_q, state_d;
    rw_e    last_rw_q, last_rw_d;
    logic   aref_en_q, aref_en_d;
    logic   wr_en_q, wr_en_d;
    logic   rd_en_q, rd_en_d;

    // State, tie-break memory and grant pulse registers.
    always_ff @(posedge sdram_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            last_rw_q <= RW_READ;
            aref_en_q <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_rw_q <= last_rw_d;
            aref_en_q <= aref_en_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
        end
    end

    // Next-state: arbitrate in ARB, otherwise wait for the owner to release the bus.
    always_comb begin
        state_d   = state_q;
        last_rw_d = last_rw_q;
        aref_en_d = 1'b0;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (init_done) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (aref_req) begin
                    state_d   = ST_AREF;
                    aref_en_d = 1'b1;
                end else if (wr_req && rd_req) begin
                    if (last_rw_q == RW_READ) begin
                        state_d = ST_WRITE;
                        wr_en_d = 1'b1;
                    end else begin
                        state_d = ST_READ;
                        rd_en_d = 1'b1;
                    end
                end else if (wr_req) begin
                    state_d = ST_WRITE;
                    wr_en_d = 1'b1;
                end else if (rd_req) begin
                    state_d = ST_READ;
                    rd_en_d = 1'b1;
                end
            end
            ST_AREF: begin
                if (aref_done) begin
                    state_d = ST_ARB;
                end
            end
            ST_WRITE: begin
                last_rw_d = RW_WRITE;
                if (wr_done_all || wr_go_aref) begin
                    state_d = ST_ARB;
                end
            end
            ST_READ: begin
                last_rw_d = RW_READ;
                if (rd_done_all || rd_go_aref) begin
                    state_d = ST_ARB;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Pin mux: the current owner's command/address drives the bus, NOP otherwise.
    always_comb begin
        sdram_cmd   = CMD_NOP;
        sdram_addr  = '0;
        sdram_ba    = '0;
        sdram_dq_oe = 1'b0;
        case (state_q)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd = aref_cmd;
            end
            ST_WRITE: begin
                sdram_cmd   = wr_cmd;
                sdram_addr  = wr_addr;
                sdram_ba    = wr_ba;
                sdram_dq_oe = 1'b1;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_ba   = rd_ba;
            end
            default: begin
                sdram_cmd = CMD_NOP;
            end
        endcase
    end

    assign sdram_dq = wr_data;
    assign aref_en  = aref_en_q;
    assign wr_en    = wr_en_q;
    assign rd_en    = rd_en_q;

    // At most one grant pulse may be high in any cycle.
    assert property (@(posedge sdram_clk) disable iff (!rst_n)
                     $onehot0({aref_en_q, wr_en_q, rd_en_q}));

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed scenarios followed by randomized traffic, with
// every output compared each cycle against an owner-level reference model.
module tb_sdram_arbiter;

    localparam int O_INIT = 0;
    localparam int O_ARB  = 1;
    localparam int O_AREF = 2;
    localparam int O_WR   = 3;
    localparam int O_RD   = 4;

    logic        sdram_clk = 1'b0;
    logic        rst_n;
    logic [3:0]  init_cmd;
    logic [11:0] init_addr;
    logic        init_done;
    logic        aref_req, aref_done, aref_en;
    logic [3:0]  aref_cmd;
    logic        wr_req, wr_done_all, wr_go_aref, wr_en;
    logic [3:0]  wr_cmd;
    logic [11:0] wr_addr;
    logic [1:0]  wr_ba;
    logic [7:0]  wr_data;
    logic        rd_req, rd_done_all, rd_go_aref, rd_en;
    logic [3:0]  rd_cmd;
    logic [11:0] rd_addr;
    logic [1:0]  rd_ba;
    logic [3:0]  sdram_cmd;
    logic [11:0] sdram_addr;
    logic [1:0]  sdram_ba;
    logic [7:0]  sdram_dq;
    logic        sdram_dq_oe;

    sdram_arbiter #(.ADDR_BITS(12), .BA_BITS(2), .DQ_BITS(8)) dut (
        .sdram_clk(sdram_clk), .rst_n(rst_n),
        .init_cmd(init_cmd), .init_addr(init_addr), .init_done(init_done),
        .aref_req(aref_req), .aref_cmd(aref_cmd), .aref_done(aref_done), .aref_en(aref_en),
        .wr_req(wr_req), .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_ba(wr_ba), .wr_data(wr_data),
        .wr_done_all(wr_done_all), .wr_go_aref(wr_go_aref), .wr_en(wr_en),
        .rd_req(rd_req), .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_ba(rd_ba),
        .rd_done_all(rd_done_all), .rd_go_aref(rd_go_aref), .rd_en(rd_en),
        .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_ba(sdram_ba),
        .sdram_dq(sdram_dq), .sdram_dq_oe(sdram_dq_oe)
    );

    always #5 sdram_clk = ~sdram_clk;

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model: who owns the bus, who was served last, which grant is showing.
    int m_own, m_prev;
    bit m_wr_last;
    bit m_en_a, m_en_w, m_en_r;

    // Environment knobs.
    bit keep_wr, keep_rd, rnd_mode, yield_ok, inj_rd_done;
    int done_dly, own_cyc, cyc;
    int glog[$];
    int gcyc[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_own     = O_INIT;
        m_wr_last = 1'b0;
        m_en_a    = 1'b0;
        m_en_w    = 1'b0;
        m_en_r    = 1'b0;
    endtask

    task automatic model_step();
        int pick;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_en_a = 1'b0;
        m_en_w = 1'b0;
        m_en_r = 1'b0;
        pick   = O_ARB;
        case (m_own)
            O_INIT: if (init_done) m_own = O_ARB;
            O_ARB: begin
                if (aref_req)              pick = O_AREF;
                else if (wr_req && rd_req) pick = m_wr_last ? O_RD : O_WR;
                else if (wr_req)           pick = O_WR;
                else if (rd_req)           pick = O_RD;
                m_own  = pick;
                m_en_a = (pick == O_AREF);
                m_en_w = (pick == O_WR);
                m_en_r = (pick == O_RD);
            end
            O_AREF: if (aref_done) m_own = O_ARB;
            O_WR: begin
                m_wr_last = 1'b1;
                if (wr_done_all || wr_go_aref) m_own = O_ARB;
            end
            default: begin
                m_wr_last = 1'b0;
                if (rd_done_all || rd_go_aref) m_own = O_ARB;
            end
        endcase
    endtask

    task automatic check_outputs();
        logic [3:0]  ec;
        logic [11:0] ea;
        logic [1:0]  eb;
        logic        eo;
        ec = 4'b0111; ea = '0; eb = '0; eo = 1'b0;
        case (m_own)
            O_INIT: begin ec = init_cmd; ea = init_addr; end
            O_AREF: ec = aref_cmd;
            O_WR:   begin ec = wr_cmd; ea = wr_addr; eb = wr_ba; eo = 1'b1; end
            O_RD:   begin ec = rd_cmd; ea = rd_addr; eb = rd_ba; end
            default: ec = 4'b0111;
        endcase
        chk("cmd",     32'(sdram_cmd),   32'(ec));
        chk("addr",    32'(sdram_addr),  32'(ea));
        chk("ba",      32'(sdram_ba),    32'(eb));
        chk("dq",      32'(sdram_dq),    32'(wr_data));
        chk("dq_oe",   32'(sdram_dq_oe), 32'(eo));
        chk("aref_en", 32'(aref_en),     32'(m_en_a));
        chk("wr_en",   32'(wr_en),       32'(m_en_w));
        chk("rd_en",   32'(rd_en),       32'(m_en_r));
    endtask

    // Behaviour of the four masters around the arbiter for the coming cycle.
    task automatic env_cycle();
        aref_done = 1'b0; wr_done_all = 1'b0; wr_go_aref = 1'b0;
        rd_done_all = 1'b0; rd_go_aref = 1'b0;
        if (m_own != m_prev) own_cyc = 0;
        else                 own_cyc++;
        m_prev = m_own;
        if (rnd_mode) begin
            if (own_cyc == 0 && m_own >= O_AREF) done_dly = $urandom_range(1, 8);
            yield_ok = 1'($urandom_range(0, 1));
        end
        if (m_en_a) aref_req = 1'b0;
        if (m_en_w && !keep_wr) wr_req = 1'b0;
        if (m_en_r && !keep_rd) rd_req = 1'b0;
        case (m_own)
            O_AREF: if (own_cyc == done_dly) aref_done = 1'b1;
            O_WR: begin
                if (yield_ok && aref_req && own_cyc >= 1) wr_go_aref = 1'b1;
                else if (own_cyc == done_dly)             wr_done_all = 1'b1;
            end
            O_RD: begin
                if (yield_ok && aref_req && own_cyc >= 1) rd_go_aref = 1'b1;
                else if (own_cyc == done_dly)             rd_done_all = 1'b1;
            end
            default: ;
        endcase
        if (rnd_mode) begin
            init_cmd  = 4'($urandom);  init_addr = 12'($urandom);
            aref_cmd  = 4'($urandom);
            wr_cmd    = 4'($urandom);  wr_addr   = 12'($urandom);
            wr_ba     = 2'($urandom);  wr_data   = 8'($urandom);
            rd_cmd    = 4'($urandom);  rd_addr   = 12'($urandom);
            rd_ba     = 2'($urandom);
            if (!aref_req && $urandom_range(0, 19) == 0) aref_req = 1'b1;
            if (!wr_req && m_own != O_WR && $urandom_range(0, 3) == 0) wr_req = 1'b1;
            if (!rd_req && m_own != O_RD && $urandom_range(0, 3) == 0) rd_req = 1'b1;
            if (m_own != O_AREF && $urandom_range(0, 15) == 0) aref_done   = 1'b1;
            if (m_own != O_WR   && $urandom_range(0, 15) == 0) wr_done_all = 1'b1;
            if (m_own != O_WR   && $urandom_range(0, 15) == 0) wr_go_aref  = 1'b1;
            if (m_own != O_RD   && $urandom_range(0, 15) == 0) rd_done_all = 1'b1;
            if (m_own != O_RD   && $urandom_range(0, 15) == 0) rd_go_aref  = 1'b1;
        end
        if (inj_rd_done) rd_done_all = 1'b1;
        inj_rd_done = 1'b0;
    endtask

    // One clock: drive, check outputs, advance the model, move to the next negedge.
    task automatic step_cycle();
        env_cycle();
        if (!rst_n) model_reset();
        #1;
        check_outputs();
        if (aref_en) begin glog.push_back(0); gcyc.push_back(cyc); end
        if (wr_en)   begin glog.push_back(1); gcyc.push_back(cyc); end
        if (rd_en)   begin glog.push_back(2); gcyc.push_back(cyc); end
        model_step();
        cyc++;
        @(posedge sdram_clk);
        @(negedge sdram_clk);
    endtask

    task automatic run_until(input int own, input int budget, input string tag);
        int n = 0;
        while (m_own != own && n < budget) begin
            step_cycle();
            n++;
        end
        chk(tag, 32'(m_own), 32'(own));
    endtask

    initial begin
        int exp3[4];
        int exp4[3];
        int n;
        exp3[0] = 1; exp3[1] = 2; exp3[2] = 1; exp3[3] = 2;
        exp4[0] = 1; exp4[1] = 0; exp4[2] = 1;
        rst_n = 1'b0; init_done = 1'b0;
        init_cmd = 4'b0010; init_addr = 12'h400;
        aref_req = 1'b0; aref_cmd = 4'b0001;
        wr_req = 1'b0; wr_cmd = 4'b0100; wr_addr = '0; wr_ba = '0; wr_data = '0;
        rd_req = 1'b0; rd_cmd = 4'b0101; rd_addr = '0; rd_ba = '0;
        aref_done = 1'b0; wr_done_all = 1'b0; wr_go_aref = 1'b0;
        rd_done_all = 1'b0; rd_go_aref = 1'b0;
        keep_wr = 1'b0; keep_rd = 1'b0; rnd_mode = 1'b0; yield_ok = 1'b0; inj_rd_done = 1'b0;
        done_dly = 6; own_cyc = 0; cyc = 0;
        model_reset();
        m_prev = O_INIT;
        @(negedge sdram_clk);

        // Reset: pins follow the init sequencer, no grants.
        repeat (3) step_cycle();
        chk("rst_cmd",  32'(sdram_cmd),  32'(4'b0010));
        chk("rst_addr", 32'(sdram_addr), 32'(12'h400));
        chk("rst_en",   32'({aref_en, wr_en, rd_en}), 32'(0));
        chk("rst_oe",   32'(sdram_dq_oe), 32'(0));
        rst_n = 1'b1;
        repeat (2) step_cycle();
        init_done = 1'b1;
        step_cycle();
        chk("arb_nop", 32'(sdram_cmd), 32'(4'b0111));

        // Refresh beats a simultaneous write request.
        aref_req = 1'b1; wr_req = 1'b1; done_dly = 3;
        step_cycle();
        chk("t2_aref_en", 32'(aref_en), 32'(1));
        chk("t2_cmd",     32'(sdram_cmd), 32'(4'b0001));
        run_until(O_WR, 20, "t2_wr_timeout");
        chk("t2_wr_en", 32'(wr_en), 32'(1));

        // Write owner drives its own bus; read inputs have no effect.
        wr_cmd = 4'b0100; wr_addr = 12'h005; wr_data = 8'hA5; wr_ba = 2'b10; rd_cmd = 4'b0101;
        #1;
        chk("t5_cmd",  32'(sdram_cmd),  32'(4'b0100));
        chk("t5_addr", 32'(sdram_addr), 32'(12'h005));
        chk("t5_ba",   32'(sdram_ba),   32'(2'b10));
        chk("t5_dq",   32'(sdram_dq),   32'(8'hA5));
        chk("t5_oe",   32'(sdram_dq_oe), 32'(1));

        // Both held high: grants alternate, one NOP cycle between owners.
        done_dly = 6; keep_wr = 1'b1; keep_rd = 1'b1; rd_req = 1'b1;
        glog.delete(); gcyc.delete();
        n = 0;
        while (glog.size() < 4 && n < 60) begin step_cycle(); n++; end
        chk("t3_count", 32'(glog.size()), 32'(4));
        for (int i = 0; i < 4 && i < glog.size(); i++) begin
            chk($sformatf("t3_order%0d", i), 32'(glog[i]), 32'(exp3[i]));
            if (i > 0) chk($sformatf("t3_gap%0d", i), 32'(gcyc[i] - gcyc[i-1]), 32'(8));
        end

        // Writer yields for a pending refresh and is re-granted afterwards.
        run_until(O_RD, 20, "t4_rd_timeout");
        keep_rd = 1'b0; rd_req = 1'b0;
        run_until(O_WR, 20, "t4_wr_timeout");
        aref_req = 1'b1; yield_ok = 1'b1;
        glog.delete(); gcyc.delete();
        n = 0;
        while (glog.size() < 3 && n < 40) begin step_cycle(); n++; end
        chk("t4_count", 32'(glog.size()), 32'(3));
        for (int i = 0; i < 3 && i < glog.size(); i++)
            chk($sformatf("t4_order%0d", i), 32'(glog[i]), 32'(exp4[i]));
        keep_wr = 1'b0; yield_ok = 1'b0;

        // Reset in the middle of a read.
        rd_req = 1'b1;
        run_until(O_RD, 40, "t6_rd_timeout");
        rst_n = 1'b0; init_done = 1'b0;
        #1;
        chk("t6_rd_en", 32'(rd_en),       32'(0));
        chk("t6_oe",    32'(sdram_dq_oe), 32'(0));
        chk("t6_cmd",   32'(sdram_cmd),   32'(init_cmd));
        inj_rd_done = 1'b1;
        step_cycle();
        rst_n = 1'b1; inj_rd_done = 1'b1;
        repeat (2) step_cycle();
        chk("t6_stay_init", 32'(sdram_addr), 32'(init_addr));
        init_done = 1'b1;
        repeat (3) step_cycle();

        // Randomized traffic.
        rnd_mode = 1'b1;
        repeat (2500) step_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
